// File: rtl/tl_ul_host_arbiter.sv
// rtl/tl_ul_host_arbiter.sv - N-host to 1-device TileLink-UL A/D channel arbiter
// Round-robin A arbitration with burst/stall lock; D routed back by source base/mask.
module tl_ul_host_arbiter #(
    parameter int NumHosts    = 4,
    parameter int DataWidth   = 64,
    parameter int AddrWidth   = 56,
    parameter int SourceWidth = 4,
    parameter int SizeWidth   = 3,
    parameter logic [NumHosts*SourceWidth-1:0] SourceBase = '0,
    parameter logic [NumHosts*SourceWidth-1:0] SourceMask = '0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumHosts-1:0]                host_a_valid_i,
    output logic [NumHosts-1:0]                host_a_ready_o,
    input  logic [NumHosts*3-1:0]              host_a_opcode_i,
    input  logic [NumHosts*SizeWidth-1:0]      host_a_size_i,
    input  logic [NumHosts*SourceWidth-1:0]    host_a_source_i,
    input  logic [NumHosts*AddrWidth-1:0]      host_a_address_i,
    input  logic [NumHosts*DataWidth/8-1:0]    host_a_mask_i,
    input  logic [NumHosts*DataWidth-1:0]      host_a_data_i,
    output logic                               dev_a_valid_o,
    input  logic                               dev_a_ready_i,
    output logic [2:0]                         dev_a_opcode_o,
    output logic [SizeWidth-1:0]               dev_a_size_o,
    output logic [SourceWidth-1:0]             dev_a_source_o,
    output logic [AddrWidth-1:0]               dev_a_address_o,
    output logic [DataWidth/8-1:0]             dev_a_mask_o,
    output logic [DataWidth-1:0]               dev_a_data_o,
    input  logic                               dev_d_valid_i,
    output logic                               dev_d_ready_o,
    input  logic [2:0]                         dev_d_opcode_i,
    input  logic [SizeWidth-1:0]               dev_d_size_i,
    input  logic [SourceWidth-1:0]             dev_d_source_i,
    input  logic                               dev_d_denied_i,
    input  logic [DataWidth-1:0]               dev_d_data_i,
    output logic [NumHosts-1:0]                host_d_valid_o,
    input  logic [NumHosts-1:0]                host_d_ready_i,
    output logic [2:0]                         host_d_opcode_o,
    output logic [SizeWidth-1:0]               host_d_size_o,
    output logic [SourceWidth-1:0]             host_d_source_o,
    output logic                               host_d_denied_o,
    output logic [DataWidth-1:0]               host_d_data_o,
    output logic                               unroutable_o
);
    localparam int MaskWidth = DataWidth / 8;
    localparam int BytesLog  = $clog2(MaskWidth);
    localparam int PtrW      = (NumHosts > 1) ? $clog2(NumHosts) : 1;
    localparam int MaxShift  = (2**SizeWidth - 1) - BytesLog;
    localparam int CntW      = (MaxShift > 0) ? MaxShift : 1;

    logic [PtrW-1:0] r_rr_ptr;
    logic [PtrW-1:0] r_lock_idx;
    logic            r_locked;
    logic [CntW-1:0] r_beats_left;
    logic            r_unroutable;

    logic [PtrW-1:0] w_search_idx;
    logic [PtrW-1:0] w_idx;
    logic            w_found;
    logic [PtrW-1:0] w_grant;
    logic            w_any;
    logic            w_fire;
    logic            w_multi;
    logic [CntW-1:0] w_beats_m1;
    logic [PtrW-1:0] w_next_ptr;
    logic            w_d_hit;
    logic [PtrW-1:0] w_d_tgt;

    // Descending offset scan so the host closest to r_rr_ptr wins.
    always_comb begin
        w_found      = 1'b0;
        w_search_idx = r_rr_ptr;
        w_idx        = '0;
        for (int k = NumHosts - 1; k >= 0; k--) begin
            w_idx = PtrW'((int'(r_rr_ptr) + k) % NumHosts);
            if (host_a_valid_i[w_idx]) begin
                w_found      = 1'b1;
                w_search_idx = w_idx;
            end
        end
    end

    assign w_grant       = r_locked ? r_lock_idx : w_search_idx;
    assign w_any         = r_locked | w_found;
    assign dev_a_valid_o = !rst_i && w_any && host_a_valid_i[w_grant];
    assign w_fire        = dev_a_valid_o && dev_a_ready_i;
    assign w_next_ptr    = (w_grant == PtrW'(NumHosts - 1)) ? '0 : w_grant + PtrW'(1);

    always_comb begin
        dev_a_opcode_o  = '0;
        dev_a_size_o    = '0;
        dev_a_source_o  = '0;
        dev_a_address_o = '0;
        dev_a_mask_o    = '0;
        dev_a_data_o    = '0;
        host_a_ready_o  = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (PtrW'(i) == w_grant) begin
                dev_a_opcode_o  = host_a_opcode_i[i*3 +: 3];
                dev_a_size_o    = host_a_size_i[i*SizeWidth +: SizeWidth];
                dev_a_source_o  = host_a_source_i[i*SourceWidth +: SourceWidth];
                dev_a_address_o = host_a_address_i[i*AddrWidth +: AddrWidth];
                dev_a_mask_o    = host_a_mask_i[i*MaskWidth +: MaskWidth];
                dev_a_data_o    = host_a_data_i[i*DataWidth +: DataWidth];
                host_a_ready_o[i] = !rst_i && w_any && dev_a_ready_i;
            end
        end
    end

    // Only full/partial puts larger than one bus word span several beats.
    always_comb begin
        w_multi    = ((dev_a_opcode_o == 3'd0) || (dev_a_opcode_o == 3'd1)) &&
                     (int'(dev_a_size_o) > BytesLog);
        w_beats_m1 = '0;
        if (w_multi) begin
            w_beats_m1 = CntW'((1 << (int'(dev_a_size_o) - BytesLog)) - 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr     <= '0;
            r_lock_idx   <= '0;
            r_locked     <= 1'b0;
            r_beats_left <= '0;
            r_unroutable <= 1'b0;
        end else begin
            r_unroutable <= dev_d_valid_i && !w_d_hit;
            if (w_fire) begin
                if (r_beats_left == '0) begin
                    r_rr_ptr <= w_next_ptr;
                    if (w_multi) begin
                        r_beats_left <= w_beats_m1;
                        r_locked     <= 1'b1;
                        r_lock_idx   <= w_grant;
                    end else begin
                        r_locked <= 1'b0;
                    end
                end else begin
                    r_beats_left <= r_beats_left - CntW'(1);
                    if (r_beats_left == CntW'(1)) begin
                        r_locked <= 1'b0;
                    end
                end
            end else if (dev_a_valid_o && !r_locked) begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_grant;
            end
        end
    end

    // Lowest-index match wins when host source ranges overlap.
    always_comb begin
        w_d_hit = 1'b0;
        w_d_tgt = '0;
        for (int i = NumHosts - 1; i >= 0; i--) begin
            if ((dev_d_source_i & ~SourceMask[i*SourceWidth +: SourceWidth]) ==
                (SourceBase[i*SourceWidth +: SourceWidth] & ~SourceMask[i*SourceWidth +: SourceWidth])) begin
                w_d_hit = 1'b1;
                w_d_tgt = PtrW'(i);
            end
        end
    end

    always_comb begin
        host_d_valid_o = '0;
        for (int i = 0; i < NumHosts; i++) begin
            host_d_valid_o[i] = !rst_i && w_d_hit && (w_d_tgt == PtrW'(i)) && dev_d_valid_i;
        end
    end

    assign dev_d_ready_o   = !rst_i && (w_d_hit ? host_d_ready_i[w_d_tgt] : 1'b1);
    assign host_d_opcode_o = dev_d_opcode_i;
    assign host_d_size_o   = dev_d_size_i;
    assign host_d_source_o = dev_d_source_i;
    assign host_d_denied_o = dev_d_denied_i;
    assign host_d_data_o   = dev_d_data_i;
    assign unroutable_o    = r_unroutable && !rst_i;
endmodule

// File: tb/tb_tl_ul_host_arbiter.sv
// tb/tb_tl_ul_host_arbiter.sv - self-checking bench for tl_ul_host_arbiter
module tb_tl_ul_host_arbiter;
    localparam int NH = 4, DW = 64, AW = 56, SW = 4, ZW = 3, MW = 8;
    localparam logic [NH*SW-1:0] SBASE = {4'd3, 4'd2, 4'd1, 4'd0};
    localparam logic [NH*SW-1:0] SMASK = {4'b0100, 4'd0, 4'd0, 4'd0};

    logic clk, rst_i;
    logic [NH-1:0]    host_a_valid_i, host_a_ready_o;
    logic [NH*3-1:0]  host_a_opcode_i;
    logic [NH*ZW-1:0] host_a_size_i;
    logic [NH*SW-1:0] host_a_source_i;
    logic [NH*AW-1:0] host_a_address_i;
    logic [NH*MW-1:0] host_a_mask_i;
    logic [NH*DW-1:0] host_a_data_i;
    logic dev_a_valid_o, dev_a_ready_i;
    logic [2:0] dev_a_opcode_o;
    logic [ZW-1:0] dev_a_size_o;
    logic [SW-1:0] dev_a_source_o;
    logic [AW-1:0] dev_a_address_o;
    logic [MW-1:0] dev_a_mask_o;
    logic [DW-1:0] dev_a_data_o;
    logic dev_d_valid_i, dev_d_ready_o, dev_d_denied_i;
    logic [2:0] dev_d_opcode_i;
    logic [ZW-1:0] dev_d_size_i;
    logic [SW-1:0] dev_d_source_i;
    logic [DW-1:0] dev_d_data_i;
    logic [NH-1:0] host_d_valid_o, host_d_ready_i;
    logic [2:0] host_d_opcode_o;
    logic [ZW-1:0] host_d_size_o;
    logic [SW-1:0] host_d_source_o;
    logic host_d_denied_o;
    logic [DW-1:0] host_d_data_o;
    logic unroutable_o;

    tl_ul_host_arbiter #(
        .NumHosts(NH), .DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW), .SizeWidth(ZW),
        .SourceBase(SBASE), .SourceMask(SMASK)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .host_a_valid_i(host_a_valid_i), .host_a_ready_o(host_a_ready_o),
        .host_a_opcode_i(host_a_opcode_i), .host_a_size_i(host_a_size_i),
        .host_a_source_i(host_a_source_i), .host_a_address_i(host_a_address_i),
        .host_a_mask_i(host_a_mask_i), .host_a_data_i(host_a_data_i),
        .dev_a_valid_o(dev_a_valid_o), .dev_a_ready_i(dev_a_ready_i),
        .dev_a_opcode_o(dev_a_opcode_o), .dev_a_size_o(dev_a_size_o),
        .dev_a_source_o(dev_a_source_o), .dev_a_address_o(dev_a_address_o),
        .dev_a_mask_o(dev_a_mask_o), .dev_a_data_o(dev_a_data_o),
        .dev_d_valid_i(dev_d_valid_i), .dev_d_ready_o(dev_d_ready_o),
        .dev_d_opcode_i(dev_d_opcode_i), .dev_d_size_i(dev_d_size_i),
        .dev_d_source_i(dev_d_source_i), .dev_d_denied_i(dev_d_denied_i),
        .dev_d_data_i(dev_d_data_i),
        .host_d_valid_o(host_d_valid_o), .host_d_ready_i(host_d_ready_i),
        .host_d_opcode_o(host_d_opcode_o), .host_d_size_o(host_d_size_o),
        .host_d_source_o(host_d_source_o), .host_d_denied_o(host_d_denied_o),
        .host_d_data_o(host_d_data_o), .unroutable_o(unroutable_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host-side stimulus state
    logic [NH-1:0] hv;
    logic [2:0]    hop[NH];
    logic [ZW-1:0] hsize[NH];
    logic [SW-1:0] hsrc[NH];
    logic [AW-1:0] haddr[NH];
    logic [DW-1:0] hdata[NH];
    logic [MW-1:0] hmask[NH];
    int            hrem[NH];
    logic          a_ready;
    logic          dv, dden;
    logic [2:0]    dop;
    logic [ZW-1:0] dsz;
    logic [SW-1:0] dsrc;
    logic [DW-1:0] ddata;
    logic [NH-1:0] dhr;

    // Reference model: next-priority host, host owning the link, beats still owed
    int   m_rr, m_owner, m_left;
    logic m_unr_pend;
    int   n_chk, n_fail;
    int   last_g;
    logic last_fire;
    int   obs_g;
    logic [SW-1:0] obs_src;
    logic obs_av, obs_ddr, obs_unr;
    logic [NH-1:0] obs_hdv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbeats(input logic [2:0] op, input logic [ZW-1:0] sz);
        if ((op == 3'd0 || op == 3'd1) && sz > 3) return 1 << (sz - 3);
        return 1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NH; i++) begin
            host_a_valid_i[i]            = hv[i];
            host_a_opcode_i[i*3 +: 3]    = hop[i];
            host_a_size_i[i*ZW +: ZW]    = hsize[i];
            host_a_source_i[i*SW +: SW]  = hsrc[i];
            host_a_address_i[i*AW +: AW] = haddr[i];
            host_a_mask_i[i*MW +: MW]    = hmask[i];
            host_a_data_i[i*DW +: DW]    = hdata[i];
        end
        dev_a_ready_i  = a_ready;
        dev_d_valid_i  = dv;
        dev_d_opcode_i = dop;
        dev_d_size_i   = dsz;
        dev_d_source_i = dsrc;
        dev_d_denied_i = dden;
        dev_d_data_i   = ddata;
        host_d_ready_i = dhr;
    endtask

    task automatic step();
        int g, t, b;
        logic ev, edr, fire;
        logic [NH-1:0] er, ehv;
        drive();
        #1;
        obs_av = dev_a_valid_o; obs_src = dev_a_source_o; obs_ddr = dev_d_ready_o;
        obs_hdv = host_d_valid_o; obs_unr = unroutable_o;
        obs_g = -1;
        for (int i = 0; i < NH; i++) if (host_a_ready_o[i]) obs_g = i;
        g = m_owner;
        if (g < 0) begin
            for (int k = 0; k < NH; k++) begin
                if (hv[(m_rr + k) % NH]) begin
                    g = (m_rr + k) % NH;
                    break;
                end
            end
        end
        ev = (g >= 0) && hv[g];
        er = '0;
        if (g >= 0) er[g] = a_ready;
        chk("a_valid", dev_a_valid_o, ev);
        chk("a_ready_vec", host_a_ready_o, er);
        if (ev) begin
            chk("a_opcode", dev_a_opcode_o, hop[g]);
            chk("a_size", dev_a_size_o, hsize[g]);
            chk("a_source", dev_a_source_o, hsrc[g]);
            chk("a_address", dev_a_address_o, haddr[g]);
            chk("a_mask", dev_a_mask_o, hmask[g]);
            chk("a_data", dev_a_data_o, hdata[g]);
        end
        t = -1;
        for (int i = 0; i < NH; i++) begin
            if (t < 0 && ((dsrc & ~SMASK[i*SW +: SW]) == (SBASE[i*SW +: SW] & ~SMASK[i*SW +: SW])))
                t = i;
        end
        ehv = '0;
        if (t >= 0) ehv[t] = dv;
        edr = (t >= 0) ? dhr[t] : 1'b1;
        chk("d_valid_vec", host_d_valid_o, ehv);
        chk("d_ready", dev_d_ready_o, edr);
        chk("d_fields", {host_d_opcode_o, host_d_size_o, host_d_source_o, host_d_denied_o},
            {dop, dsz, dsrc, dden});
        chk("d_data", host_d_data_o, ddata);
        chk("unroutable", unroutable_o, m_unr_pend);
        m_unr_pend = dv && (t < 0);
        fire = ev && a_ready;
        last_fire = fire;
        last_g = g;
        if (fire) begin
            if (m_left == 0) begin
                m_rr = (g + 1) % NH;
                b = nbeats(hop[g], hsize[g]);
                if (b > 1) begin
                    m_owner = g;
                    m_left = b - 1;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_owner = -1;
            end
        end else if (ev && m_owner < 0) begin
            m_owner = g;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive();
            #1;
            chk("rst_a_valid", dev_a_valid_o, 1'b0);
            chk("rst_a_ready", host_a_ready_o, '0);
            chk("rst_d_ready", dev_d_ready_o, 1'b0);
            chk("rst_d_valid", host_d_valid_o, '0);
            chk("rst_unroutable", unroutable_o, 1'b0);
            @(negedge clk);
        end
        rst_i = 1'b0;
        m_rr = 0; m_owner = -1; m_left = 0; m_unr_pend = 1'b0;
    endtask

    task automatic new_msg(input int i);
        int sel;
        sel = $urandom_range(0, 2);
        hv[i]    = 1'b1;
        hop[i]   = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd1 : 3'd4;
        hsize[i] = ZW'($urandom_range(0, 7));
        hsrc[i]  = SW'($urandom);
        haddr[i] = {$urandom, $urandom};
        hdata[i] = {$urandom, $urandom};
        hmask[i] = MW'($urandom);
        hrem[i]  = nbeats(hop[i], hsize[i]);
    endtask

    task automatic set_get(input int i);
        hv[i] = 1'b1; hop[i] = 3'd4; hsize[i] = 3'd3; hsrc[i] = SW'(i);
        haddr[i] = AW'(64'h1000 * (i + 1)); hdata[i] = DW'(i); hmask[i] = 8'hff;
    endtask

    initial begin
        int t1g[4];
        int t1r[4];
        int fires1;
        n_chk = 0; n_fail = 0;
        m_rr = 0; m_owner = -1; m_left = 0; m_unr_pend = 1'b0;
        rst_i = 1'b1;
        hv = '1; a_ready = 1'b1;
        dv = 1'b1; dden = 1'b0; dop = 3'd1; dsz = 3'd3; dsrc = 4'd9; ddata = 64'h55; dhr = '1;
        for (int i = 0; i < NH; i++) begin
            set_get(i);
            hrem[i] = 0;
        end
        @(negedge clk);
        do_reset();
        dv = 1'b0;

        // Two hosts with continuous single-beat Gets alternate
        t1g = '{0, 2, 0, 2};
        t1r = '{1, 3, 1, 3};
        hv = '0; set_get(0); set_get(2); a_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("t1_grant", obs_g, t1g[n]);
            chk("t1_rr", m_rr, t1r[n]);
        end

        // 8-beat Put from host 1 holds the link against host 3
        hv = '0; do_reset();
        set_get(1); hop[1] = 3'd0; hsize[1] = 3'd6; set_get(3);
        fires1 = 0;
        for (int n = 0; n < 9; n++) begin
            step();
            chk("t2_grant", obs_g, (n < 8) ? 1 : 3);
            if (obs_g == 1) begin
                fires1++;
                hdata[1] = {$urandom, $urandom};
                if (fires1 == 8) hv[1] = 1'b0;
            end
        end
        chk("t2_beats", fires1, 8);

        // Stalled host 2 keeps the grant when host 0 arrives
        hv = '0; do_reset();
        set_get(2); a_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t3_hold_src", obs_src, 2);
            chk("t3_hold_valid", obs_av, 1'b1);
        end
        set_get(0);
        for (int n = 0; n < 2; n++) begin
            step();
            chk("t3_stay_src", obs_src, 2);
        end
        a_ready = 1'b1;
        step();
        chk("t3_fire2", obs_g, 2);
        hv[2] = 1'b0;
        step();
        chk("t3_fire0", obs_g, 0);
        hv = '0;

        // D routed to host 2 with back-pressure
        dv = 1'b1; dsrc = 4'd2; dhr = 4'b1011; ddata = 64'hd00d;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t4_hvalid", obs_hdv, 4'b0100);
            chk("t4_stall", obs_ddr, 1'b0);
        end
        dhr = '1;
        step();
        chk("t4_fire", obs_ddr, 1'b1);
        chk("t4_hvalid_fire", obs_hdv, 4'b0100);

        // Unroutable source is dropped and flagged one cycle later
        dsrc = 4'd9;
        step();
        chk("t5_ready", obs_ddr, 1'b1);
        chk("t5_hvalid", obs_hdv, 4'b0000);
        chk("t5_unr_now", obs_unr, 1'b0);
        dv = 1'b0;
        step();
        chk("t5_unr_next", obs_unr, 1'b1);
        step();
        chk("t5_unr_clear", obs_unr, 1'b0);

        // Reset during beat 4 of an 8-beat Put
        do_reset();
        set_get(2); hop[2] = 3'd0; hsize[2] = 3'd6;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t6_beat", obs_g, 2);
        end
        do_reset();
        chk("t6_rr", m_rr, 0);
        chk("t6_owner", m_owner, -1);
        set_get(0);
        step();
        chk("t6_first", obs_g, 0);
        chk("t6_rr_after", m_rr, 1);
        hv[0] = 1'b0;
        step();
        chk("t6_put_restart", obs_g, 2);
        chk("t6_locked", m_owner, 2);

        // Randomized traffic on both channels
        hv = '0;
        for (int i = 0; i < NH; i++) hrem[i] = 0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                hv = '0;
                for (int i = 0; i < NH; i++) hrem[i] = 0;
                do_reset();
            end
            for (int i = 0; i < NH; i++) begin
                if (!hv[i]) begin
                    if (hrem[i] > 0) hv[i] = ($urandom_range(0, 9) < 7);
                    else if ($urandom_range(0, 9) < 3) new_msg(i);
                end
            end
            a_ready = ($urandom_range(0, 9) < 7);
            dv = $urandom_range(0, 1);
            dsrc = SW'($urandom);
            dhr = NH'($urandom);
            dop = 3'($urandom);
            dsz = ZW'($urandom);
            dden = $urandom_range(0, 1);
            ddata = {$urandom, $urandom};
            step();
            if (last_fire) begin
                hrem[last_g]--;
                if (hrem[last_g] > 0) begin
                    hdata[last_g] = {$urandom, $urandom};
                    hmask[last_g] = MW'($urandom);
                    if ($urandom_range(0, 4) == 0) hv[last_g] = 1'b0;
                end else if ($urandom_range(0, 1) == 0) begin
                    new_msg(last_g);
                end else begin
                    hv[last_g] = 1'b0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
